// File: rtl/pc_sequencer.sv
// Program-counter register and FETCH/DECODE/EXECUTE phase sequencer.
// Drives the PC adder and loads either its result or a branch target.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  input  logic [WIDTH-1:0] pc_next_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [2:0]       state,
  output logic             fetch_en,
  output logic             retire,
  output logic [7:0]       instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t st;

  assign state    = st;
  assign fetch_en = (st == FETCH) && !stall;
  assign retire   = (st == EXECUTE) && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      pc_out      <= RESET_PC;
      instr_count <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (start) st <= FETCH;
        end
        FETCH: begin
          if (!stall) st <= DECODE;
        end
        DECODE: begin
          if (!stall) st <= EXECUTE;
        end
        EXECUTE: begin
          if (!stall) begin
            pc_out <= branch_en ? branch_target
                                : pc_next_in;
            if (instr_count != 8'hFF)
              instr_count <= instr_count + 8'd1;
            st <= halt ? HALTED : FETCH;
          end
        end
        HALTED: st <= HALTED;
        // encodings 5-7 fall back to IDLE
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected
// retire events, a negedge monitor pops and checks them.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, branch_en, halt;
  logic [7:0] branch_target, pc_next_in, pc_out, instr_count;
  logic [2:0] state;
  logic       fetch_en, retire;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] cnt;
  } ret_t;

  ret_t sbq[$];

  always #5 clk = ~clk;

  assign pc_next_in = pc_out + 8'd1;

  pc_sequencer #(
    .WIDTH(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .stall(stall),
    .branch_en(branch_en),
    .branch_target(branch_target),
    .halt(halt),
    .pc_next_in(pc_next_in),
    .pc_out(pc_out),
    .state(state),
    .fetch_en(fetch_en),
    .retire(retire),
    .instr_count(instr_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ret(input logic [7:0] p,
                         input logic [7:0] c);
    ret_t e;
    e.pc  = p;
    e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic clr_in;
    start         = 1'b0;
    stall         = 1'b0;
    branch_en     = 1'b0;
    halt          = 1'b0;
    branch_target = 8'h00;
  endtask

  task automatic do_reset;
    clr_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic launch;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    ret_t e;
    if (rst_n === 1'b1 && retire === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("retire_unexpected", {31'd0, retire}, 0);
      end else begin
        e = sbq.pop_front();
        chk("ret_pc", {24'd0, pc_out}, {24'd0, e.pc});
        chk("ret_cnt", {24'd0, instr_count},
            {24'd0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by 100000");
    $fatal(1, "timeout");
  end

  int st_t[17] = '{1, 2, 3, 1, 2, 3, 1, 1, 2,
                   2, 2, 2, 2, 2, 3, 3, 1};
  int sl_t[17] = '{0, 0, 0, 0, 0, 0, 1, 0, 1,
                   1, 1, 1, 1, 0, 1, 0, 0};
  int pc_t[17] = '{0, 0, 0, 1, 1, 1, 2, 2, 2,
                   2, 2, 2, 2, 2, 2, 2, 3};

  initial begin
    clr_in();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_state", state, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_retire", retire, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold", state, 0);

    // four straight-line instructions
    for (int k = 0; k < 4; k++) exp_ret(k[7:0], k[7:0]);
    launch();
    for (int c = 1; c <= 12; c++) begin
      chk("t1_fetch_en", fetch_en, (c % 3) == 1);
      chk("t1_pc", pc_out, (c - 1) / 3);
      tick();
    end
    chk("t1_pc_end", pc_out, 8'h04);
    chk("t1_cnt", instr_count, 4);
    do_reset();

    // branch in 2nd EXECUTE, stray pulses in FETCH/DECODE
    exp_ret(8'h00, 8'd0);
    exp_ret(8'h01, 8'd1);
    exp_ret(8'h40, 8'd2);
    launch();
    branch_target = 8'h40;
    for (int c = 1; c <= 9; c++) begin
      branch_en = (c == 1 || c == 2 || c == 6);
      tick();
    end
    branch_en = 1'b0;
    chk("t2_pc", pc_out, 8'h41);
    chk("t2_cnt", instr_count, 3);
    do_reset();

    // stalls in FETCH, DECODE (5 cycles at PC=02), EXECUTE
    exp_ret(8'h00, 8'd0);
    exp_ret(8'h01, 8'd1);
    exp_ret(8'h02, 8'd2);
    launch();
    for (int i = 0; i < 17; i++) begin
      stall = sl_t[i][0];
      #1;
      chk("t3_state", state, st_t[i]);
      chk("t3_pc", pc_out, pc_t[i]);
      chk("t3_cnt", instr_count, pc_t[i]);
      chk("t3_fetch_en", fetch_en,
          st_t[i] == 1 && sl_t[i] == 0);
      chk("t3_retire", retire,
          st_t[i] == 3 && sl_t[i] == 0);
      tick();
    end
    stall = 1'b0;
    do_reset();

    // wrap FE->FF->00 and count saturation
    for (int k = 0; k < 300; k++) begin
      if (k == 0) exp_ret(8'h00, 8'd0);
      else exp_ret(8'(8'hFE + k - 1),
                   (k > 255) ? 8'd255 : k[7:0]);
    end
    launch();
    branch_en     = 1'b1;
    branch_target = 8'hFE;
    for (int c = 1; c <= 900; c++) begin
      if (c == 4) branch_en = 1'b0;
      tick();
    end
    chk("t4_pc", pc_out, 8'h29);
    chk("t4_cnt", instr_count, 255);
    do_reset();

    // halt together with branch, then sticky HALTED
    exp_ret(8'h00, 8'd0);
    launch();
    branch_en     = 1'b1;
    halt          = 1'b1;
    branch_target = 8'h10;
    for (int c = 1; c <= 3; c++) tick();
    clr_in();
    chk("t5_pc", pc_out, 8'h10);
    chk("t5_state", state, 4);
    chk("t5_cnt", instr_count, 1);
    for (int i = 0; i < 20; i++) begin
      start         = i[0];
      branch_en     = ~i[0];
      halt          = i[1];
      stall         = i[2];
      branch_target = 8'h77;
      #1;
      chk("t5_hold_state", state, 4);
      chk("t5_hold_pc", pc_out, 8'h10);
      chk("t5_hold_cnt", instr_count, 1);
      chk("t5_hold_retire", retire, 0);
      chk("t5_hold_fetch", fetch_en, 0);
      tick();
    end
    do_reset();

    // async reset mid-DECODE at PC=05
    for (int k = 0; k < 5; k++) exp_ret(k[7:0], k[7:0]);
    launch();
    for (int c = 1; c <= 16; c++) tick();
    chk("t6_pre_state", state, 2);
    chk("t6_pre_pc", pc_out, 8'h05);
    chk("t6_pre_cnt", instr_count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pc", pc_out, 8'h00);
    chk("t6_state", state, 0);
    chk("t6_cnt", instr_count, 0);
    chk("t6_retire", retire, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
